// File: rtl/gate_pkg.sv
// Shared encodings for the two-input gate self-test: function codes,
// expected truth tables (bit index = {A,B}), checker state and result record.
package gate_pkg;

    localparam logic [2:0] GATE_AND  = 3'd0;
    localparam logic [2:0] GATE_OR   = 3'd1;
    localparam logic [2:0] GATE_NOT  = 3'd2;
    localparam logic [2:0] GATE_NAND = 3'd3;
    localparam logic [2:0] GATE_NOR  = 3'd4;
    localparam logic [2:0] GATE_XOR  = 3'd5;
    localparam logic [2:0] GATE_XNOR = 3'd6;
    localparam logic [2:0] GATE_RSVD = 3'd7;

    // Bits [3:0] correspond to {A,B} = 11,10,01,00
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOT  = 4'b0011;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_REPORT
    } chk_state_t;

    typedef struct packed {
        logic [3:0] result_vec;
        logic [3:0] err_vec;
        logic       pass;
        logic       bad_sel;
    } chk_result_t;

endpackage

// File: rtl/gate_truth_rom.sv
// Combinational gate_sel -> expected truth table lookup; reserved code yields 0.
module gate_truth_rom
    import gate_pkg::*;
(
    input  logic [2:0] gate_sel,
    output logic [3:0] expected
);

    always_comb begin
        expected = 4'h0;
        case (gate_sel)
            GATE_AND:  expected = TT_AND;
            GATE_OR:   expected = TT_OR;
            GATE_NOT:  expected = TT_NOT;
            GATE_NAND: expected = TT_NAND;
            GATE_NOR:  expected = TT_NOR;
            GATE_XOR:  expected = TT_XOR;
            GATE_XNOR: expected = TT_XNOR;
            default:   expected = 4'h0;
        endcase
    end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Walks {A,B} through 00..11 on a gate under test, samples the response after
// a settle window and reports per-vector results plus a pass verdict.
module gate_truth_table_checker
    import gate_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] gate_sel,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result_vec,
    output logic [3:0] err_vec,
    output logic       bad_sel
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    chk_state_t  state, state_nxt;
    chk_result_t res;
    logic [2:0]  sel_q;
    logic [1:0]  idx;
    logic [1:0]  idx_inc;
    logic [3:0]  cnt;
    logic [3:0]  exp_tt;
    logic        err_bit;
    logic [3:0]  err_next;
    logic        sel_rsvd;

    gate_truth_rom u_rom (
        .gate_sel (sel_q),
        .expected (exp_tt)
    );

    assign sel_rsvd = (gate_sel == GATE_RSVD);
    assign idx_inc  = idx + 2'd1;
    assign err_bit  = y_in ^ exp_tt[idx];

    // Error mask including the sample being taken this cycle, so the verdict
    // can be registered on the final SAMPLE edge and be valid during REPORT.
    always_comb begin
        err_next      = res.err_vec;
        err_next[idx] = err_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = sel_rsvd ? ST_REPORT : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                state_nxt = (idx == 2'd3) ? ST_REPORT : ST_SETTLE;
            end
            ST_REPORT: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res   <= '0;
            sel_q <= '0;
            idx   <= '0;
            cnt   <= '0;
            a_out <= 1'b0;
            b_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sel_q <= gate_sel;
                        idx   <= 2'd0;
                        cnt   <= 4'd0;
                        a_out <= 1'b0;
                        b_out <= 1'b0;
                        res   <= '0;
                        if (sel_rsvd) begin
                            res.err_vec <= 4'hF;
                            res.bad_sel <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt != SETTLE_LAST) cnt <= cnt + 4'd1;
                end
                ST_SAMPLE: begin
                    res.result_vec[idx] <= y_in;
                    res.err_vec[idx]    <= err_bit;
                    cnt                 <= 4'd0;
                    if (idx == 2'd3) begin
                        res.pass <= (err_next == 4'h0);
                    end else begin
                        // Next vector's stimulus is launched here so it is
                        // stable for the whole following SETTLE window.
                        idx   <= idx_inc;
                        a_out <= idx_inc[1];
                        b_out <= idx_inc[0];
                    end
                end
                ST_REPORT: begin
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign result_vec = res.result_vec;
    assign err_vec    = res.err_vec;
    assign pass       = res.pass;
    assign bad_sel    = res.bad_sel;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Scoreboard bench: stimulus pushes expected reports, a negedge monitor pops
// and compares on every done pulse from either checker instance.
module tb_gate_truth_table_checker;

    typedef struct {
        int         edge_no;
        logic [3:0] res;
        logic [3:0] err;
        logic       pass;
        logic       bad;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int total = 0;
    int bad   = 0;

    exp_t sb1[$];
    exp_t sb3[$];

    // DUT1: SETTLE_CYCLES = 1, combinational gate model
    logic       rst1 = 1'b1, start1 = 1'b0, y1;
    logic [2:0] gs1 = 3'd0;
    logic       a1, b1, busy1, done1, pass1, bsel1;
    logic [3:0] rv1, ev1;
    int         m1_sel = 0;
    logic       m1_stuck = 1'b0;

    // DUT3: SETTLE_CYCLES = 3, NOT(A) delayed by two registers
    logic       rst3 = 1'b1, start3 = 1'b0, y3;
    logic [2:0] gs3 = 3'd0;
    logic       a3, b3, busy3, done3, pass3, bsel3;
    logic [3:0] rv3, ev3;
    logic       d1 = 1'b0, d2 = 1'b0;

    function automatic logic gmodel(int s, logic a, logic b);
        case (s)
            0: return a & b;
            1: return a | b;
            2: return ~a;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return a ^ b;
            6: return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    assign y1 = m1_stuck ? 1'b0 : gmodel(m1_sel, a1, b1);

    always @(posedge clk) begin
        d1 <= ~a3;
        d2 <= d1;
    end
    assign y3 = d2;

    gate_truth_table_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .gate_sel(gs1), .y_in(y1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
        .result_vec(rv1), .err_vec(ev1), .bad_sel(bsel1)
    );

    gate_truth_table_checker #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .gate_sel(gs3), .y_in(y3),
        .a_out(a3), .b_out(b3), .busy(busy3), .done(done3), .pass(pass3),
        .result_vec(rv3), .err_vec(ev3), .bad_sel(bsel3)
    );

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic check_report(string tag, exp_t e, logic [3:0] rv, logic [3:0] ev,
                                logic p, logic bs);
        chk({tag, "_done_edge"}, edge_n, e.edge_no);
        chk({tag, "_result_vec"}, rv, e.res);
        chk({tag, "_err_vec"}, ev, e.err);
        chk({tag, "_pass"}, p, e.pass);
        chk({tag, "_bad_sel"}, bs, e.bad);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (done1) begin
            if (sb1.size() == 0) begin
                total++; bad++;
                $display("FAIL dut1_unexpected_done got=1 want=0 (t=%0t)", $time);
            end else check_report("dut1", sb1.pop_front(), rv1, ev1, pass1, bsel1);
        end
        if (done3) begin
            if (sb3.size() == 0) begin
                total++; bad++;
                $display("FAIL dut3_unexpected_done got=1 want=0 (t=%0t)", $time);
            end else check_report("dut3", sb3.pop_front(), rv3, ev3, pass3, bsel3);
        end
    end

    // Drive start for one acceptance edge; returns that edge's index.
    task automatic pulse_start1(input logic [2:0] sel, output int acc);
        @(negedge clk);
        start1 = 1'b1;
        gs1    = sel;
        @(posedge clk);
        #1;
        acc    = edge_n;
        start1 = 1'b0;
    endtask

    task automatic push1(int e, logic [3:0] r, logic [3:0] er, logic p, logic bs);
        exp_t x;
        x.edge_no = e; x.res = r; x.err = er; x.pass = p; x.bad = bs;
        sb1.push_back(x);
    endtask

    task automatic wait_drain(string name, int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (sb1.size() == 0 && sb3.size() == 0) break;
        end
        if (i == bound) begin
            total++; bad++;
            $display("FAIL %s_timeout got=pending want=drained", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {a1, b1, busy1, done1, pass1, rv1, ev1, bsel1}, 15'h0);
        chk("reset_outputs3", {a3, b3, busy3, done3, pass3, rv3, ev3, bsel3}, 15'h0);
        rst1 = 1'b0;
        rst3 = 1'b0;

        // AND pass with stimulus stepping every two cycles
        m1_sel = 0;
        pulse_start1(3'd0, acc);
        push1(acc + 8, 4'b1000, 4'b0000, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            logic [1:0] want_ab;
            @(negedge clk);
            want_ab = 2'((k - 1) / 2);
            chk($sformatf("and_ab_cycle%0d", k), {a1, b1}, want_ab);
            chk($sformatf("and_busy_cycle%0d", k), busy1, 1'b1);
        end
        wait_drain("and", 40);
        @(negedge clk);
        chk("and_held_result", {rv1, ev1, pass1}, {4'b1000, 4'b0000, 1'b1});
        chk("and_idle_busy", busy1, 1'b0);

        // XOR with output stuck at 0
        m1_stuck = 1'b1;
        pulse_start1(3'd5, acc);
        push1(acc + 8, 4'b0000, 4'b0110, 1'b0, 1'b0);
        wait_drain("xor_stuck", 40);
        m1_stuck = 1'b0;

        // Reserved code: immediate report, stimulus idle
        pulse_start1(3'd7, acc);
        push1(acc, 4'b0000, 4'hF, 1'b0, 1'b1);
        @(negedge clk);
        chk("rsvd_ab_cycle1", {a1, b1}, 2'b00);
        @(negedge clk);
        chk("rsvd_ab_cycle2", {a1, b1}, 2'b00);
        wait_drain("rsvd", 10);

        // Extra start pulses and gate_sel changes mid-run are ignored
        m1_sel = 1;
        pulse_start1(3'd1, acc);
        push1(acc + 8, 4'b1110, 4'b0000, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        start1 = 1'b1; gs1 = 3'd0;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        start1 = 1'b1; gs1 = 3'd7;
        @(negedge clk);
        start1 = 1'b0;
        wait_drain("mid_start", 40);
        repeat (14) @(negedge clk);

        // Start held high: back-to-back runs, done in cycles 9 and 19
        m1_sel = 3;
        @(negedge clk);
        start1 = 1'b1; gs1 = 3'd3;
        @(posedge clk);
        #1;
        acc = edge_n;
        push1(acc + 8, 4'b0111, 4'b0000, 1'b1, 1'b0);
        push1(acc + 18, 4'b0111, 4'b0000, 1'b1, 1'b0);
        wait_drain("held_start", 60);
        start1 = 1'b0;
        repeat (12) @(negedge clk);

        // Reset in cycle 4: no done, clean outputs, then a clean rerun
        m1_sel = 0;
        pulse_start1(3'd0, acc);
        repeat (4) @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", {a1, b1, busy1, done1, pass1, rv1, ev1, bsel1}, 15'h0);
        rst1 = 1'b0;
        repeat (12) @(negedge clk);
        pulse_start1(3'd0, acc);
        push1(acc + 8, 4'b1000, 4'b0000, 1'b1, 1'b0);
        wait_drain("after_rst", 40);

        // NOT(A) with two-register delayed response, SETTLE_CYCLES = 3
        begin
            exp_t x;
            @(negedge clk);
            start3 = 1'b1; gs3 = 3'd2;
            @(posedge clk);
            #1;
            start3 = 1'b0;
            x.edge_no = edge_n + 16; x.res = 4'b0011; x.err = 4'b0000;
            x.pass = 1'b1; x.bad = 1'b0;
            sb3.push_back(x);
            gs3 = 3'd0;
        end
        wait_drain("not_delay", 60);

        repeat (5) @(negedge clk);
        chk("sb1_drained", sb1.size(), 0);
        chk("sb3_drained", sb3.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
